// File: rtl/dw_feature_streamer_if.sv
// Feature-buffer read port plus the pixel stream and row-buffer length control
// that dw_feature_streamer drives towards the window generator.
interface dw_feature_streamer_if #(
    parameter int DATA_WIDTH      = 8,
    parameter int OUT_CHANNEL_NUM = 18,
    parameter int ADDR_WIDTH      = 17,
    parameter int DEPTH           = 9
);
    logic                                  rd_en;
    logic [ADDR_WIDTH-1:0]                 rd_addr;
    logic [OUT_CHANNEL_NUM*DATA_WIDTH-1:0] rd_data;
    logic [OUT_CHANNEL_NUM*DATA_WIDTH-1:0] data_out;
    logic                                  valid_out;
    logic [DEPTH-1:0]                      buff_len_ctrl;
    logic                                  buff_len_rst;

    modport master (
        output rd_en, rd_addr, data_out, valid_out, buff_len_ctrl, buff_len_rst,
        input  rd_data
    );

    modport slave (
        input  rd_en, rd_addr, data_out, valid_out, buff_len_ctrl, buff_len_rst,
        output rd_data
    );
endinterface

// File: rtl/dw_feature_streamer.sv
// Streams a stored feature map in raster order, one pixel per cycle, with an
// optional 1-pixel zero border; also loads the downstream row-buffer length.
module dw_feature_streamer #(
    parameter int DATA_WIDTH      = 8,
    parameter int OUT_CHANNEL_NUM = 18,
    parameter int MAX_WIDTH       = 320,
    parameter int MAX_HEIGHT      = 320,
    parameter int ADDR_WIDTH      = 17,
    parameter int DEPTH           = $clog2(MAX_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              start,
    input  logic [$clog2(MAX_WIDTH+1)-1:0]    img_width,
    input  logic [$clog2(MAX_HEIGHT+1)-1:0]   img_height,
    input  logic                              pad_en,
    output logic                              busy,
    output logic                              done,
    dw_feature_streamer_if.master             fbus
);
    localparam int WW  = $clog2(MAX_WIDTH + 1);
    localparam int HW  = $clog2(MAX_HEIGHT + 1);
    localparam int EWW = WW + 2;
    localparam int EHW = HW + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_STREAM,
        S_DRAIN,
        S_FAIL
    } state_t;

    state_t                  state_q, state_d;
    logic [EWW-1:0]          ew_q, ew_d, c_q, c_d;
    logic [EHW-1:0]          eh_q, eh_d, r_q, r_d;
    logic                    pad_q, pad_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DEPTH-1:0]        blc_q, blc_d;
    logic                    blr_q, blr_d;
    logic                    vld_q, vld_d;
    logic                    bdr_q, bdr_d;
    logic                    done_q, done_d;

    logic [EWW-1:0]          ew_n;
    logic [EHW-1:0]          eh_n;
    logic                    cfg_ok, col_end, row_end, border;

    always_comb begin
        ew_n    = EWW'(img_width) + (pad_en ? EWW'(2) : '0);
        eh_n    = EHW'(img_height) + (pad_en ? EHW'(2) : '0);
        cfg_ok  = (img_width != '0) && (img_height != '0)
               && (ew_n >= EWW'(3)) && (eh_n >= EHW'(3))
               && (img_width <= WW'(MAX_WIDTH)) && (img_height <= HW'(MAX_HEIGHT));
        col_end = (c_q == ew_q - EWW'(1));
        row_end = (r_q == eh_q - EHW'(1));
        border  = pad_q && ((c_q == '0) || (r_q == '0) || col_end || row_end);

        state_d = state_q;
        ew_d    = ew_q;
        eh_d    = eh_q;
        c_d     = c_q;
        r_d     = r_q;
        pad_d   = pad_q;
        addr_d  = addr_q;
        blc_d   = blc_q;
        blr_d   = 1'b0;
        vld_d   = 1'b0;
        bdr_d   = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        state_d = S_CFG;
                        ew_d    = ew_n;
                        eh_d    = eh_n;
                        pad_d   = pad_en;
                        c_d     = '0;
                        r_d     = '0;
                        addr_d  = '0;
                        blc_d   = DEPTH'(ew_n - EWW'(2));
                        blr_d   = 1'b1;
                    end else begin
                        state_d = S_FAIL;
                        done_d  = 1'b1;
                    end
                end
            end
            S_CFG: state_d = S_STREAM;
            S_STREAM: begin
                vld_d = 1'b1;
                bdr_d = border;
                if (!border) addr_d = addr_q + ADDR_WIDTH'(1);
                if (col_end) begin
                    c_d = '0;
                    if (row_end) state_d = S_DRAIN;
                    else         r_d = r_q + EHW'(1);
                end else begin
                    c_d = c_q + EWW'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            ew_q    <= '0;
            eh_q    <= '0;
            c_q     <= '0;
            r_q     <= '0;
            pad_q   <= 1'b0;
            addr_q  <= '0;
            blc_q   <= '0;
            blr_q   <= 1'b0;
            vld_q   <= 1'b0;
            bdr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ew_q    <= ew_d;
            eh_q    <= eh_d;
            c_q     <= c_d;
            r_q     <= r_d;
            pad_q   <= pad_d;
            addr_q  <= addr_d;
            blc_q   <= blc_d;
            blr_q   <= blr_d;
            vld_q   <= vld_d;
            bdr_q   <= bdr_d;
            done_q  <= done_d;
        end
    end

    // The buffer's read register is the output stage; only the valid/border
    // flags are delayed here to line up with rd_data.
    assign fbus.rd_en         = (state_q == S_STREAM) && !border;
    assign fbus.rd_addr       = addr_q;
    assign fbus.data_out      = (vld_q && !bdr_q) ? fbus.rd_data : '0;
    assign fbus.valid_out     = vld_q;
    assign fbus.buff_len_ctrl = blc_q;
    assign fbus.buff_len_rst  = blr_q;
    assign busy               = (state_q == S_CFG) || (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign done               = done_q;
endmodule

// File: tb/tb_dw_feature_streamer.sv
// Self-checking bench for dw_feature_streamer: frames are checked cycle by cycle
// against a positional model of the padded raster and a synchronous-read buffer.
module tb_dw_feature_streamer;
    localparam int DW  = 8;
    localparam int OCN = 18;
    localparam int MW  = 320;
    localparam int MH  = 320;
    localparam int AW  = 17;
    localparam int DEP = $clog2(MW);
    localparam int BW  = DW * OCN;
    localparam int WW  = $clog2(MW + 1);
    localparam int HW  = $clog2(MH + 1);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          pad_en = 1'b0;
    logic [WW-1:0] img_width = '0;
    logic [HW-1:0] img_height = '0;
    logic          busy, done;

    int unsigned    checks = 0;
    int unsigned    failures = 0;
    logic [111:0]   salt = '0;
    logic [DEP-1:0] exp_blc = '0;

    dw_feature_streamer_if #(
        .DATA_WIDTH(DW), .OUT_CHANNEL_NUM(OCN), .ADDR_WIDTH(AW), .DEPTH(DEP)
    ) fbus ();

    dw_feature_streamer #(
        .DATA_WIDTH(DW), .OUT_CHANNEL_NUM(OCN), .MAX_WIDTH(MW),
        .MAX_HEIGHT(MH), .ADDR_WIDTH(AW), .DEPTH(DEP)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .img_width(img_width),
        .img_height(img_height), .pad_en(pad_en), .busy(busy), .done(done),
        .fbus(fbus)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] word(input int k);
        return {salt, 32'(k)};
    endfunction

    // Synchronous-read feature buffer: word k holds k in its low 32 bits.
    always @(posedge clk) if (fbus.rd_en) fbus.rd_data <= word(int'(fbus.rd_addr));

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit border_at(input int pos, input int ew, input int eh, input bit p);
        int r, c;
        r = pos / ew;
        c = pos % ew;
        return p && (r == 0 || r == eh - 1 || c == 0 || c == ew - 1);
    endfunction

    function automatic int interior_idx(input int pos, input int ew, input int w, input bit p);
        return (pos / ew - int'(p)) * w + (pos % ew - int'(p));
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_rd_en"}, fbus.rd_en, 0);
        check({tag, "_rd_addr"}, fbus.rd_addr, 0);
        check({tag, "_data"},  fbus.data_out, 0);
        check({tag, "_valid"}, fbus.valid_out, 0);
        check({tag, "_blc"},   fbus.buff_len_ctrl, 0);
        check({tag, "_blr"},   fbus.buff_len_rst, 0);
    endtask

    // Called at a negedge with the DUT idle; start is asserted immediately.
    task automatic run_frame(input int w, input int h, input bit p,
                             input int restart_at, input int abort_at);
        int  ew, eh, n, last;
        bit  ok, exp_rd, exp_v;
        ew = w + 2 * int'(p);
        eh = h + 2 * int'(p);
        ok = (w > 0) && (h > 0) && (ew >= 3) && (eh >= 3) && (w <= MW) && (h <= MH);
        n  = ew * eh;
        last = ok ? n + 3 : 3;
        img_width  = WW'(w);
        img_height = HW'(h);
        pad_en     = p;
        start      = 1'b1;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start      = 1'b0;
                img_width  = WW'($urandom);
                img_height = HW'($urandom);
                pad_en     = 1'($urandom);
            end
            if (k == restart_at)     start = 1'b1;
            if (k == restart_at + 1) start = 1'b0;
            if (k == abort_at) begin
                rstn = 1'b0;
                #1;
                exp_blc = '0;
                check_all_zero("abort");
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    check("abort_hold_done", done, 0);
                    check("abort_hold_valid", fbus.valid_out, 0);
                end
                rstn = 1'b1;
                return;
            end
            if (ok) begin
                if (k == 1) exp_blc = DEP'(ew - 2);
                check("busy", busy, (k <= n + 2));
                check("done", done, (k == n + 3));
                check("blr",  fbus.buff_len_rst, (k == 1));
                check("blc",  fbus.buff_len_ctrl, exp_blc);
                exp_rd = (k >= 2) && (k <= n + 1) && !border_at(k - 2, ew, eh, p);
                check("rd_en", fbus.rd_en, exp_rd);
                if (exp_rd) check("rd_addr", fbus.rd_addr, interior_idx(k - 2, ew, w, p));
                exp_v = (k >= 3) && (k <= n + 2);
                check("valid", fbus.valid_out, exp_v);
                if (exp_v)
                    check("data", fbus.data_out,
                          border_at(k - 3, ew, eh, p) ? '0 : word(interior_idx(k - 3, ew, w, p)));
            end else begin
                check("bad_busy",  busy, 0);
                check("bad_done",  done, (k == 1));
                check("bad_blr",   fbus.buff_len_rst, 0);
                check("bad_blc",   fbus.buff_len_ctrl, exp_blc);
                check("bad_rd_en", fbus.rd_en, 0);
                check("bad_valid", fbus.valid_out, 0);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        run_frame(4, 3, 1'b0, 0, 0);
        run_frame(3, 3, 1'b1, 0, 0);
        run_frame(4, 3, 1'b0, 6, 0);
        run_frame(2, 5, 1'b0, 0, 0);
        run_frame(2, 5, 1'b1, 0, 0);
        run_frame(4, 3, 1'b0, 0, 7);
        run_frame(4, 3, 1'b0, 0, 0);
        run_frame(320, 3, 1'b0, 0, 0);
        run_frame(321, 3, 1'b0, 0, 0);
        run_frame(5, 0, 1'b1, 0, 0);
        run_frame(1, 1, 1'b1, 0, 0);

        for (int i = 0; i < 24; i++) begin
            salt = {$urandom, $urandom, $urandom, 16'($urandom)};
            run_frame(int'($urandom_range(0, 10)), int'($urandom_range(0, 6)),
                      1'($urandom), 0, 0);
        end

        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("tail_done", done, 0);
            check("tail_valid", fbus.valid_out, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dw_feature_streamer.md
# dw_feature_streamer

Frame-level source for the depthwise conv pre-processing path. It reads a stored feature map from a synchronous-read on-chip buffer and emits it as a gap-free raster-order pixel stream, one pixel (all channels) per cycle, with optional 1-pixel zero border. It also drives the row-buffer length control (`buff_len_ctrl`, `buff_len_rst`) that the window generator downstream needs before the first pixel arrives.

## Interface

Parameters:
- DATA_WIDTH, 8, bits per channel sample
- OUT_CHANNEL_NUM, 18, channels packed per pixel
- MAX_WIDTH, 320, max unpadded image width
- MAX_HEIGHT, 320, max unpadded image height
- ADDR_WIDTH, 17, feature-buffer address width (≥ clog2(MAX_WIDTH*MAX_HEIGHT))
- DEPTH, $clog2(MAX_WIDTH), width of buff_len_ctrl

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  single-cycle frame start, sampled only in IDLE
- img_width  in  $clog2(MAX_WIDTH+1)  unpadded width W
- img_height  in  $clog2(MAX_HEIGHT+1)  unpadded height H
- pad_en  in  1  add 1-pixel zero border on all sides
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end
- rd_en  out  1  feature-buffer read enable
- rd_addr  out  ADDR_WIDTH  feature-buffer read address
- rd_data  in  OUT_CHANNEL_NUM*DATA_WIDTH  read data, valid 1 cycle after rd_en
- data_out  out  OUT_CHANNEL_NUM*DATA_WIDTH  pixel to pre-processor
- valid_out  out  1  data_out valid
- buff_len_ctrl  out  DEPTH  row-buffer length = EW-2
- buff_len_rst  out  1  one-cycle row-buffer length load/reset

## Operation

- Effective size: EW = W+2·pad_en, EH = H+2·pad_en; W, H, pad_en latched on accepted start.
- FSM: IDLE → CFG → STREAM → DRAIN → IDLE; IDLE → FAIL → IDLE on invalid config.
- IDLE: busy=0; start accepted; start in any other state ignored.
- Invalid config: W=0, H=0, EW<3, EH<3, W>MAX_WIDTH or H>MAX_HEIGHT → FAIL for one cycle, done=1, no rd_en, no valid_out, no buff_len_rst, buff_len_ctrl unchanged.
- CFG (1 cycle): buff_len_ctrl ← EW-2 (held until next CFG), buff_len_rst=1.
- STREAM: EW·EH cycles, one position per cycle, row-major, column counter c∈[0,EW-1], row counter r∈[0,EH-1], c wraps to 0 and r increments at EW-1.
- Position is border iff pad_en and (r=0 or r=EH-1 or c=0 or c=EW-1): rd_en=0, pixel = all zeros.
- Otherwise rd_en=1, rd_addr = linear interior index, starting 0, +1 per interior position (no multiplier; running counter), final value W·H-1.
- Output stage: one register stage; border flag delayed 1 cycle to select 0 vs rd_data, so order and spacing are preserved with no gaps.
- DRAIN (1 cycle): final pixel presented; then done=1 one cycle with state back to IDLE.
- Reset mid-operation: all state cleared asynchronously, no done pulse, stream truncated.

## Timing

- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, data_out=0, valid_out=0, buff_len_ctrl=0, buff_len_rst=0.
- Start sampled at edge T0; T1 CFG (buff_len_rst=1, buff_len_ctrl valid); T2 first position issued; first valid_out at T3.
- valid_out high for exactly EW·EH consecutive cycles, T3..T2+EW·EH.
- done high at cycle T3+EW·EH; busy high T1..T2+EW·EH, low when done high.
- Invalid config: done at T1, busy stays 0.
- rd_data consumed exactly 1 cycle after rd_en; no backpressure exists.
- Next start accepted in the cycle done is high (state already IDLE).

## Test plan

- W=4,H=3,pad_en=0, buffer word k = k -> buff_len_rst at T1 with buff_len_ctrl=2; valid_out 12 contiguous cycles from T3, data_out = 0..11; done at T15.
- W=3,H=3,pad_en=1 -> buff_len_ctrl=3; 25 outputs; border positions 0, interior rows 1..3 cols 1..3 = 0..8 in order; exactly 9 rd_en pulses, rd_addr 0..8.
- start re-pulsed mid-STREAM of a 4x3 frame -> ignored, single 12-pixel stream, single done; start in done cycle -> new CFG next cycle.
- W=2,H=5,pad_en=0 -> done at T1, no valid_out, no rd_en, buff_len_rst stays 0; same W with pad_en=1 (EW=4) streams 28 pixels.
- rstn low after 5th valid_out of 4x3 frame -> all outputs 0 immediately, no done; fresh start afterwards streams full 12 pixels from address 0.
- W=320,H=3,pad_en=0 -> buff_len_ctrl=318, rd_addr reaches 959, 960 contiguous valid cycles.
